// File: rtl/elevator_if.sv
// Call-button / status bundle between the elevator controller and its host.
interface elevator_if #(parameter int FLOORS = 4);
  localparam int FW = (FLOORS > 1) ? $clog2(FLOORS) : 1;

  logic              tick_in;
  logic [FLOORS-1:0] req;
  logic [FW-1:0]     floor;
  logic              moving;
  logic              dir_up;
  logic              door_open;
  logic [FLOORS-1:0] pending;

  modport master (output tick_in, req,
                  input  floor, moving, dir_up, door_open, pending);
  modport slave  (input  tick_in, req,
                  output floor, moving, dir_up, door_open, pending);
endinterface

// File: rtl/elevator_ctrl.sv
// Single-car elevator controller: latches calls, travels in tick-timed steps,
// serves the current direction first and holds the door on repeated calls.
module elevator_ctrl #(
  parameter int FLOORS       = 4,
  parameter int TRAVEL_TICKS = 2,
  parameter int DOOR_TICKS   = 3
) (
  input  logic     clk,
  input  logic     rst,
  elevator_if.slave bus
);
  localparam int FW   = (FLOORS > 1) ? $clog2(FLOORS) : 1;
  localparam int TMAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  state_t            r_state;
  logic [FW-1:0]     r_floor;
  logic              r_dir_up;
  logic              r_moving;
  logic              r_door;
  logic [FLOORS-1:0] r_pending;
  logic [CW-1:0]     r_tcnt;
  logic [CW-1:0]     r_dcnt;
  logic              r_sync1, r_sync2, r_edge;

  logic              w_tick;
  logic [FLOORS-1:0] w_clr;
  logic [FW-1:0]     w_up_floor, w_dn_floor;
  logic              w_above, w_below, w_above_up, w_below_dn;

  function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (FW'(i) > f && p[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (FW'(i) < f && p[i]) r = 1'b1;
    return r;
  endfunction

  assign w_tick     = r_sync2 & ~r_edge;
  assign w_clr      = (r_state == DOOR) ? (FLOORS'(1) << r_floor) : '0;
  assign w_up_floor = r_floor + FW'(1);
  assign w_dn_floor = r_floor - FW'(1);
  assign w_above    = any_above(r_pending, r_floor);
  assign w_below    = any_below(r_pending, r_floor);
  assign w_above_up = any_above(r_pending, w_up_floor);
  assign w_below_dn = any_below(r_pending, w_dn_floor);

  // tick_in is unrelated to clk: two flops for metastability, a third for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= bus.tick_in;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pending <= '0;
    else     r_pending <= (r_pending | bus.req) & ~w_clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_floor  <= '0;
      r_dir_up <= 1'b1;
      r_moving <= 1'b0;
      r_door   <= 1'b0;
      r_tcnt   <= '0;
      r_dcnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_pending[r_floor]) begin
            r_state <= DOOR;
            r_door  <= 1'b1;
            r_dcnt  <= '0;
          end else if (w_above && (r_dir_up || !w_below)) begin
            r_state  <= MOVE_UP;
            r_moving <= 1'b1;
            r_dir_up <= 1'b1;
            r_tcnt   <= '0;
          end else if (w_below) begin
            r_state  <= MOVE_DOWN;
            r_moving <= 1'b1;
            r_dir_up <= 1'b0;
            r_tcnt   <= '0;
          end
        end
        MOVE_UP: begin
          if (w_tick) begin
            if (r_tcnt == CW'(TRAVEL_TICKS - 1)) begin
              r_tcnt <= '0;
              if (r_floor == FW'(FLOORS - 1)) begin
                r_state  <= IDLE;
                r_moving <= 1'b0;
              end else begin
                r_floor <= w_up_floor;
                if (r_pending[w_up_floor]) begin
                  r_state  <= DOOR;
                  r_moving <= 1'b0;
                  r_door   <= 1'b1;
                  r_dcnt   <= '0;
                end else if (!w_above_up) begin
                  r_state  <= IDLE;
                  r_moving <= 1'b0;
                end
              end
            end else begin
              r_tcnt <= r_tcnt + CW'(1);
            end
          end
        end
        MOVE_DOWN: begin
          if (w_tick) begin
            if (r_tcnt == CW'(TRAVEL_TICKS - 1)) begin
              r_tcnt <= '0;
              if (r_floor == '0) begin
                r_state  <= IDLE;
                r_moving <= 1'b0;
              end else begin
                r_floor <= w_dn_floor;
                if (r_pending[w_dn_floor]) begin
                  r_state  <= DOOR;
                  r_moving <= 1'b0;
                  r_door   <= 1'b1;
                  r_dcnt   <= '0;
                end else if (!w_below_dn) begin
                  r_state  <= IDLE;
                  r_moving <= 1'b0;
                end
              end
            end else begin
              r_tcnt <= r_tcnt + CW'(1);
            end
          end
        end
        DOOR: begin
          // a call for this floor keeps the door open from scratch
          if (bus.req[r_floor]) begin
            r_dcnt <= '0;
          end else if (w_tick) begin
            if (r_dcnt == CW'(DOOR_TICKS - 1)) begin
              r_state <= IDLE;
              r_door  <= 1'b0;
              r_dcnt  <= '0;
            end else begin
              r_dcnt <= r_dcnt + CW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.floor     = r_floor;
  assign bus.moving    = r_moving;
  assign bus.dir_up    = r_dir_up;
  assign bus.door_open = r_door;
  assign bus.pending   = r_pending;
endmodule

// File: tb/tb_elevator_ctrl.sv
// Randomized bench for elevator_ctrl against a countdown-based behavioural model.
`timescale 1ns/1ps
module tb_elevator_ctrl;
  localparam int F  = 4;
  localparam int TT = 2;
  localparam int DT = 3;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;

  elevator_if #(.FLOORS(F)) bus ();

  elevator_ctrl #(.FLOORS(F), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: no finish by 2ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // model state: remaining-tick countdowns instead of up-counters
  int         m_floor, m_left;
  bit         m_dir, m_moving, m_door;
  logic [3:0] m_pend;
  bit         th[$];

  function automatic bit up_any(input logic [3:0] p, input int f);
    return (32'(p) >> (f + 1)) != 0;
  endfunction

  function automatic bit dn_any(input logic [3:0] p, input int f);
    return (32'(p) & ((1 << f) - 1)) != 0;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_left = 0; m_dir = 1; m_moving = 0; m_door = 0; m_pend = '0;
    th = '{0, 0, 0};
  endtask

  task automatic model_edge();
    bit         tk, ua, da;
    logic [3:0] np;
    int         nf;
    // a tick is acted on two edges after the first high sample of tick_in
    tk = th[1] && !th[0];
    th.push_back(bus.tick_in);
    void'(th.pop_front());
    np = (m_pend | bus.req) & ~(m_door ? 4'(1 << m_floor) : 4'd0);
    if (!m_moving && !m_door) begin
      ua = up_any(m_pend, m_floor);
      da = dn_any(m_pend, m_floor);
      if (m_pend[m_floor]) begin
        m_door = 1; m_left = DT;
      end else if (ua || da) begin
        if (!(ua && da)) m_dir = ua;
        m_moving = 1; m_left = TT;
      end
    end else if (m_moving) begin
      if (tk) begin
        m_left--;
        if (m_left == 0) begin
          nf = m_dir ? m_floor + 1 : m_floor - 1;
          if (nf < 0 || nf > F - 1) m_moving = 0;
          else begin
            m_floor = nf;
            if (m_pend[nf]) begin
              m_moving = 0; m_door = 1; m_left = DT;
            end else if (m_dir ? up_any(m_pend, nf) : dn_any(m_pend, nf)) m_left = TT;
            else m_moving = 0;
          end
        end
      end
    end else begin
      if (bus.req[m_floor]) m_left = DT;
      else if (tk) begin
        m_left--;
        if (m_left == 0) m_door = 0;
      end
    end
    m_pend = np;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_edge();
    end
  end

  // tick_in toggles at random, clk-unrelated offsets, never on a rising clk edge
  initial begin
    bus.tick_in = 1'b0;
    forever begin
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #($urandom_range(1, 49));
      bus.tick_in = ~bus.tick_in;
    end
  end

  task automatic step(input logic [3:0] r);
    @(negedge clk);
    chk("floor",   32'(bus.floor),     32'(m_floor));
    chk("moving",  32'(bus.moving),    32'(m_moving));
    chk("dir_up",  32'(bus.dir_up),    32'(m_dir));
    chk("door",    32'(bus.door_open), 32'(m_door));
    chk("pending", 32'(bus.pending),   32'(m_pend));
    bus.req = r;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_floor"},  32'(bus.floor),     0);
    chk({tag, "_moving"}, 32'(bus.moving),    0);
    chk({tag, "_dir"},    32'(bus.dir_up),    1);
    chk({tag, "_door"},   32'(bus.door_open), 0);
    chk({tag, "_pend"},   32'(bus.pending),   0);
  endtask

  task automatic async_rst(input string tag);
    #5 rst = 1'b1;
    #1 rst_chk(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    bus.req = '0;
    repeat (3) @(negedge clk);
    rst_chk("reset");
    rst = 1'b0;

    // ground-floor call opens the door in place, then closes
    step(4'b0001);
    k = 0;
    while (!bus.door_open && k < 50) begin step(4'b0000); k++; end
    chk("d_g_door", 32'(bus.door_open), 1);
    k = 0;
    while (bus.door_open && k < 200) begin step(4'b0000); k++; end
    step(4'b0000);
    chk("d_g_closed", 32'(bus.door_open), 0);
    chk("d_g_pend",   32'(bus.pending),   0);

    // reset in mid-travel between floors 1 and 2
    step(4'b0100);
    k = 0;
    while (!(bus.floor == 2'd1 && bus.moving) && k < 300) begin step(4'b0000); k++; end
    chk("d_mid_floor", 32'(bus.floor), 1);
    async_rst("d_mid");

    // full climb to the top floor
    step(4'b1000);
    k = 0;
    while (!(bus.door_open && bus.floor == 2'd3) && k < 400) begin step(4'b0000); k++; end
    chk("d_top_floor", 32'(bus.floor),     3);
    chk("d_top_door",  32'(bus.door_open), 1);
    step(4'b0000);
    chk("d_top_pend3", 32'(bus.pending[3]), 0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) async_rst("r_rst");
      case ($urandom_range(0, 19))
        0:       step(4'(1 << $urandom_range(0, F - 1)));
        1:       step(4'($urandom_range(0, 15)));
        default: step(4'b0000);
      endcase
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
